// File: rtl/alu_decode_stage.sv
// Registered MIPS decode stage: instruction -> ALU/MDU control with valid/ready handshakes,
// an MDU busy interlock and a syscall halt latch. Optional illegal-instruction trap: ILLEGAL_TRAP_EN.
module alu_decode_stage #(
  parameter int ALUOP_W = 4,
  parameter int MDU_LAT = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ALUOP_W-1:0] out_aluop,
  output logic               out_is_syscall,
  output logic               out_is_jr,
  output logic               out_is_shamt,
  output logic               out_is_mdu,
`ifdef ILLEGAL_TRAP_EN
  output logic               out_is_illegal,
`endif
  output logic               mdu_busy,
  output logic               halted,
  input  logic               resume,
  input  logic               flush
);

  localparam int CNT_W = $clog2(MDU_LAT + 1);

  // SLL doubles as the "no ALU work" code for jr, syscall, MDU ops and mfhi/mflo.
  typedef enum logic [3:0] {
    ALU_SLL  = 4'b0000,
    ALU_SRA  = 4'b0001,
    ALU_SRL  = 4'b0010,
    ALU_ADD  = 4'b0101,
    ALU_SUB  = 4'b0110,
    ALU_AND  = 4'b0111,
    ALU_OR   = 4'b1000,
    ALU_XOR  = 4'b1001,
    ALU_NOR  = 4'b1010,
    ALU_SLT  = 4'b1011,
    ALU_SLTU = 4'b1100
  } aluop_e;

  typedef struct packed {
    aluop_e aluop;
    logic   is_syscall;
    logic   is_jr;
    logic   is_shamt;
    logic   is_mdu;
    logic   is_mfhilo;
    logic   is_illegal;
  } dec_t;

  dec_t             dec;
  logic [CNT_W-1:0] mdu_cnt;
  logic             hazard;
  logic             accept;
  logic             halt_req;

  wire [5:0] op    = instr[31:26];
  wire [5:0] funct = instr[5:0];

  // NOTE: every field gets a default before the case, so no path leaves dec unassigned (no latch).
  always_comb begin
    dec = '0;
    case (op)
      6'b000000: begin
        case (funct)
          6'b100000: dec.aluop = ALU_ADD;
          6'b100010: dec.aluop = ALU_SUB;
          6'b100100: dec.aluop = ALU_AND;
          6'b100101: dec.aluop = ALU_OR;
          6'b100110: dec.aluop = ALU_XOR;
          6'b100111: dec.aluop = ALU_NOR;
          6'b101010: dec.aluop = ALU_SLT;
          6'b101011: dec.aluop = ALU_SLTU;
          6'b000000: begin dec.aluop = ALU_SLL; dec.is_shamt = 1'b1; end
          6'b000011: begin dec.aluop = ALU_SRA; dec.is_shamt = 1'b1; end
          6'b000010: begin dec.aluop = ALU_SRL; dec.is_shamt = 1'b1; end
          6'b001000: dec.is_jr      = 1'b1;
          6'b001100: dec.is_syscall = 1'b1;
          6'b011000, 6'b011001,
          6'b011010, 6'b011011: dec.is_mdu    = 1'b1;
          6'b010000, 6'b010010: dec.is_mfhilo = 1'b1;
          default:              dec.is_illegal = 1'b1;
        endcase
      end
      6'b001000, 6'b001001: dec.aluop = ALU_ADD;
      6'b001100:            dec.aluop = ALU_AND;
      6'b001101:            dec.aluop = ALU_OR;
      6'b001110:            dec.aluop = ALU_XOR;
      6'b001010:            dec.aluop = ALU_SLT;
      6'b001011:            dec.aluop = ALU_SLTU;
      default:              dec.is_illegal = 1'b1;
    endcase
  end

`ifdef ILLEGAL_TRAP_EN
  assign halt_req = dec.is_syscall | dec.is_illegal;
  logic unused_ok;
  assign unused_ok = ^instr[25:6];
`else
  assign halt_req = dec.is_syscall;
  logic unused_ok;
  assign unused_ok = ^{instr[25:6], dec.is_illegal};
`endif

  // mfhi/mflo must also wait: they read results the MDU is still producing.
  assign mdu_busy = (mdu_cnt != '0);
  assign hazard   = mdu_busy && (dec.is_mdu || dec.is_mfhilo);
  assign in_ready = (!out_valid || out_ready) && !halted && !hazard && !flush;
  assign accept   = in_valid && in_ready;

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid      <= 1'b0;
      out_aluop      <= '0;
      out_is_syscall <= 1'b0;
      out_is_jr      <= 1'b0;
      out_is_shamt   <= 1'b0;
      out_is_mdu     <= 1'b0;
`ifdef ILLEGAL_TRAP_EN
      out_is_illegal <= 1'b0;
`endif
      mdu_cnt        <= '0;
      halted         <= 1'b0;
    end else begin
      if (flush)          out_valid <= 1'b0;
      else if (accept)    out_valid <= 1'b1;
      else if (out_ready) out_valid <= 1'b0;

      if (accept) begin
        out_aluop      <= ALUOP_W'(dec.aluop);
        out_is_syscall <= dec.is_syscall;
        out_is_jr      <= dec.is_jr;
        out_is_shamt   <= dec.is_shamt;
        out_is_mdu     <= dec.is_mdu;
`ifdef ILLEGAL_TRAP_EN
        out_is_illegal <= dec.is_illegal;
`endif
      end

      if (accept && dec.is_mdu) mdu_cnt <= CNT_W'(MDU_LAT);
      else if (mdu_busy)        mdu_cnt <= mdu_cnt - CNT_W'(1);

      // The halting instruction itself still issues; only later ones are held off.
      if (accept && halt_req) halted <= 1'b1;
      else if (resume)        halted <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_decode_stage.sv
// Scoreboard bench for alu_decode_stage: table-driven reference decoder, cycle-indexed
// interlock/halt model, directed scenarios plus randomized traffic.
module tb_alu_decode_stage;

  localparam int ALUOP_W = 6;
  localparam int MDU_LAT = 4;
  localparam int FW      = ALUOP_W + 5;
`ifdef ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] instr;
  logic [ALUOP_W-1:0] out_aluop;
  logic out_is_syscall, out_is_jr, out_is_shamt, out_is_mdu;
  logic mdu_busy, halted, resume, flush;
  logic dut_ill;

  always #5 clk = ~clk;

  alu_decode_stage #(.ALUOP_W(ALUOP_W), .MDU_LAT(MDU_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .out_valid(out_valid), .out_ready(out_ready), .out_aluop(out_aluop),
    .out_is_syscall(out_is_syscall), .out_is_jr(out_is_jr), .out_is_shamt(out_is_shamt),
    .out_is_mdu(out_is_mdu),
`ifdef ILLEGAL_TRAP_EN
    .out_is_illegal(dut_ill),
`endif
    .mdu_busy(mdu_busy), .halted(halted), .resume(resume), .flush(flush));

`ifndef ILLEGAL_TRAP_EN
  assign dut_ill = 1'b0;
`endif

  // Reference decode table: R-type rows match on funct, I-type rows match on op only.
  typedef struct {
    logic [5:0] op;
    logic [5:0] funct;
    logic [3:0] code;
    logic sys, jr, sh, mdu, mf;
  } row_t;
  typedef struct {
    logic [3:0] code;
    logic sys, jr, sh, mdu, mf, ill;
  } ref_t;

  row_t tbl[$];
  logic [FW-1:0] sb[$];
  int n_checks = 0;
  int n_fail = 0;

  // Model state: cycle index, MDU free cycle, output-valid and halt flags.
  int  cyc = 0;
  int  mdu_free_at = 0;
  bit  m_valid = 0;
  bit  m_halted = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void add_row(input logic [5:0] op, input logic [5:0] f, input logic [3:0] c,
                                  input logic sy, input logic j, input logic s, input logic m,
                                  input logic mf);
    row_t r;
    r.op = op; r.funct = f; r.code = c; r.sys = sy; r.jr = j; r.sh = s; r.mdu = m; r.mf = mf;
    tbl.push_back(r);
  endfunction

  function automatic ref_t ref_decode(input logic [31:0] ins);
    ref_t d;
    d = '{code: 4'd0, sys: 0, jr: 0, sh: 0, mdu: 0, mf: 0, ill: 1};
    foreach (tbl[i]) begin
      if ((tbl[i].op == 6'd0) ? (ins[31:26] == 6'd0 && ins[5:0] == tbl[i].funct)
                              : (ins[31:26] == tbl[i].op)) begin
        d = '{code: tbl[i].code, sys: tbl[i].sys, jr: tbl[i].jr, sh: tbl[i].sh,
              mdu: tbl[i].mdu, mf: tbl[i].mf, ill: 0};
      end
    end
    return d;
  endfunction

  function automatic logic [31:0] rtype(input logic [5:0] f);
    return {6'd0, 5'd1, 5'd2, 5'd3, 5'd4, f};
  endfunction
  function automatic logic [31:0] itype(input logic [5:0] op);
    return {op, 5'd1, 5'd2, 16'h003f};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    row_t r;
    logic [5:0] bad_ops[4];
    bad_ops = '{6'b000010, 6'b000011, 6'b100011, 6'b111111};
    w = $urandom;
    if ($urandom_range(0, 99) < 8) begin
      if ($urandom_range(0, 1) == 0) w[31:26] = bad_ops[$urandom_range(0, 3)];
      else begin w[31:26] = 6'd0; w[5:0] = 6'b111111; end
    end else begin
      r = tbl[$urandom_range(0, tbl.size() - 1)];
      w[31:26] = r.op;
      if (r.op == 6'd0) w[5:0] = r.funct;
    end
    return w;
  endfunction

  // Evaluated on the falling edge: compare handshake/status against the model, then advance it.
  task automatic model_step(output bit acc);
    ref_t d;
    bit busy, exp_ready;
    d = ref_decode(instr);
    busy = (cyc < mdu_free_at);
    exp_ready = (!m_valid || out_ready) && !m_halted && !(busy && (d.mdu || d.mf)) && !flush;
    check("in_ready", in_ready, exp_ready);
    check("out_valid", out_valid, m_valid);
    check("mdu_busy", mdu_busy, busy);
    check("halted", halted, m_halted);
    acc = in_valid && exp_ready;
    if (acc) begin
      sb.push_back({ALUOP_W'(d.code), d.sys, d.jr, d.sh, d.mdu, d.ill & TRAP});
      if (d.mdu) mdu_free_at = cyc + 1 + MDU_LAT;
    end
    if (flush) m_valid = 0;
    else if (acc) m_valid = 1;
    else if (out_ready) m_valid = 0;
    if (acc && (d.sys || (d.ill && TRAP))) m_halted = 1;
    else if (resume) m_halted = 0;
    cyc++;
  endtask

  task automatic cycle(input logic v, input logic [31:0] ins, input logic ordy, input logic fl,
                       input logic res, output bit acc);
    in_valid = v; instr = ins; out_ready = ordy; flush = fl; resume = res;
    @(negedge clk);
    model_step(acc);
    @(posedge clk); #1;
  endtask

  // Monitor: while an output is presented it must match the oldest expected entry;
  // the entry retires when execute consumes it or it is flushed.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (sb.size() == 0) check("sb_unexpected_output", 1, 0);
      else begin
        check("out_fields", {out_aluop, out_is_syscall, out_is_jr, out_is_shamt, out_is_mdu, dut_ill},
              sb[0]);
        if (out_ready || flush) void'(sb.pop_front());
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit acc;
    int held, got, n;
    logic [5:0] seq_f[6];

    add_row(6'd0, 6'b100000, 4'b0101, 0, 0, 0, 0, 0);
    add_row(6'd0, 6'b100010, 4'b0110, 0, 0, 0, 0, 0);
    add_row(6'd0, 6'b100100, 4'b0111, 0, 0, 0, 0, 0);
    add_row(6'd0, 6'b100101, 4'b1000, 0, 0, 0, 0, 0);
    add_row(6'd0, 6'b100110, 4'b1001, 0, 0, 0, 0, 0);
    add_row(6'd0, 6'b100111, 4'b1010, 0, 0, 0, 0, 0);
    add_row(6'd0, 6'b101010, 4'b1011, 0, 0, 0, 0, 0);
    add_row(6'd0, 6'b101011, 4'b1100, 0, 0, 0, 0, 0);
    add_row(6'd0, 6'b000000, 4'b0000, 0, 0, 1, 0, 0);
    add_row(6'd0, 6'b000011, 4'b0001, 0, 0, 1, 0, 0);
    add_row(6'd0, 6'b000010, 4'b0010, 0, 0, 1, 0, 0);
    add_row(6'd0, 6'b001000, 4'b0000, 0, 1, 0, 0, 0);
    add_row(6'd0, 6'b001100, 4'b0000, 1, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) add_row(6'd0, 6'b011000 + 6'(k), 4'b0000, 0, 0, 0, 1, 0);
    add_row(6'd0, 6'b010000, 4'b0000, 0, 0, 0, 0, 1);
    add_row(6'd0, 6'b010010, 4'b0000, 0, 0, 0, 0, 1);
    add_row(6'b001000, 6'd0, 4'b0101, 0, 0, 0, 0, 0);
    add_row(6'b001001, 6'd0, 4'b0101, 0, 0, 0, 0, 0);
    add_row(6'b001100, 6'd0, 4'b0111, 0, 0, 0, 0, 0);
    add_row(6'b001101, 6'd0, 4'b1000, 0, 0, 0, 0, 0);
    add_row(6'b001110, 6'd0, 4'b1001, 0, 0, 0, 0, 0);
    add_row(6'b001010, 6'd0, 4'b1011, 0, 0, 0, 0, 0);
    add_row(6'b001011, 6'd0, 4'b1100, 0, 0, 0, 0, 0);

    rst_n = 0; in_valid = 0; instr = '0; out_ready = 0; flush = 0; resume = 0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", {out_valid, out_aluop, out_is_syscall, out_is_jr, out_is_shamt,
                          out_is_mdu, dut_ill, mdu_busy, halted}, '0);
    rst_n = 1;

    // R-type stream at full rate, then I-types with funct=111111.
    seq_f = '{6'b100000, 6'b100010, 6'b100111, 6'b101011, 6'b000011, 6'b001000};
    n = 0;
    foreach (seq_f[i]) begin cycle(1, rtype(seq_f[i]), 1, 0, 0, acc); n += int'(acc); end
    cycle(1, itype(6'b001001), 1, 0, 0, acc); n += int'(acc);
    cycle(1, itype(6'b001110), 1, 0, 0, acc); n += int'(acc);
    cycle(1, itype(6'b001011), 1, 0, 0, acc); n += int'(acc);
    check("full_throughput", n, 9);
    cycle(0, '0, 1, 0, 0, acc);

    // mult then mflo: mflo held for MDU_LAT cycles.
    cycle(1, rtype(6'b011000), 1, 0, 0, acc);
    check("mult_accept", acc, 1);
    held = 0; got = 0;
    for (int i = 0; i < 20 && got == 0; i++) begin
      cycle(1, rtype(6'b010010), 1, 0, 0, acc);
      if (acc) got = 1; else held++;
    end
    check("mflo_issued", got, 1);
    check("mflo_hold_cycles", held, MDU_LAT);
    // mult then add: add flows immediately; a second mult still waits.
    cycle(1, rtype(6'b011001), 1, 0, 0, acc);
    cycle(1, rtype(6'b100000), 1, 0, 0, acc);
    check("add_after_mult", acc, 1);
    cycle(1, rtype(6'b011010), 1, 0, 0, acc);
    check("mdu_b2b_blocked", acc, 0);
    repeat (4) cycle(0, '0, 1, 0, 0, acc);

    // syscall halts; add held until the cycle after resume.
    cycle(1, rtype(6'b001100), 1, 0, 0, acc);
    check("syscall_accept", acc, 1);
    n = 0;
    repeat (5) begin cycle(1, rtype(6'b100000), 1, 0, 0, acc); n += int'(acc); end
    cycle(1, rtype(6'b100000), 1, 0, 1, acc); n += int'(acc);
    check("halt_blocks_add", n, 0);
    cycle(1, rtype(6'b100000), 1, 0, 0, acc);
    check("add_after_resume", acc, 1);
    cycle(0, '0, 1, 0, 0, acc);

    // Back-pressure for 3 cycles, then flush.
    cycle(1, rtype(6'b100100), 0, 0, 0, acc);
    n = 0;
    repeat (3) begin cycle(1, rtype(6'b100010), 0, 0, 0, acc); n += int'(acc); end
    check("stall_blocks_input", n, 0);
    cycle(1, rtype(6'b100010), 0, 1, 0, acc);
    check("flush_no_accept", acc, 0);
    check("flush_clears_valid", out_valid, 0);

    // Undecodable op: halts only with the trap build.
    cycle(0, '0, 1, 0, 0, acc);
    cycle(1, {6'b111111, 26'h0}, 1, 0, 0, acc);
    check("illegal_accept", acc, 1);
    check("illegal_halt", halted, TRAP);
    cycle(0, '0, 1, 0, 1, acc);

    // Randomized traffic.
    for (int i = 0; i < 2500; i++) begin
      cycle(($urandom_range(0, 9) < 8), rand_instr(), ($urandom_range(0, 9) < 7),
            ($urandom_range(0, 19) == 0), ($urandom_range(0, 9) < 2), acc);
    end

    // Asynchronous reset with halt latched and MDU busy.
    cycle(0, '0, 1, 0, 1, acc);
    repeat (6) cycle(0, '0, 1, 0, 0, acc);
    cycle(1, rtype(6'b011011), 1, 0, 0, acc);
    cycle(1, rtype(6'b001100), 1, 0, 0, acc);
    check("pre_reset_busy_halt", {mdu_busy, halted}, 2'b11);
    #2 rst_n = 0;
    #1;
    check("async_reset_clears", {out_valid, out_aluop, out_is_syscall, out_is_jr, out_is_shamt,
                                 out_is_mdu, dut_ill, mdu_busy, halted}, '0);
    sb.delete(); m_valid = 0; m_halted = 0; mdu_free_at = 0;
    @(posedge clk); #1;
    rst_n = 1;
    cycle(1, rtype(6'b100110), 1, 0, 0, acc);
    check("accept_after_reset", acc, 1);

    for (int i = 0; i < 20 && (sb.size() != 0 || out_valid); i++) cycle(0, '0, 1, 0, 1, acc);
    check("scoreboard_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
